// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between N producers, the round-robin arbiter and one consumer.
// The arbiter takes the slave modport; the producer/consumer side takes master.
interface mux_rr_arbiter_if #(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SELW = $clog2(N)
);
    logic [N-1:0]    req;
    logic [N*W-1:0]  din;
    logic [N-1:0]    gnt;
    logic [SELW-1:0] sel;
    logic [W-1:0]    dout;
    logic            dout_valid;
    logic            dout_ready;
    logic            busy;

    modport slave (
        input  req, din, dout_ready,
        output gnt, sel, dout, dout_valid, busy
    );

    modport master (
        output req, din, dout_ready,
        input  gnt, sel, dout, dout_valid, busy
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing one N-to-1 mux channel; the winner's word is
// captured into an output register and handed downstream by valid/ready.
module mux_rr_arbiter #(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    mux_rr_arbiter_if.slave      bus
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state;
    logic [SELW-1:0] last;
    logic [SELW-1:0] sel_p1;
    logic [W-1:0]    dout_p1;
    logic            vld_p1;
    logic [SELW-1:0] winner;
    logic            load;

    // First requester after the last winner, with exact mod-N wrap.
    function automatic logic [SELW-1:0] pick(input logic [N-1:0] r,
                                             input logic [SELW-1:0] lst);
        logic [SELW-1:0] w;
        logic            found;
        int              idx;
        w     = '0;
        found = 1'b0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(lst) + off) % N;
            if (!found && r[idx]) begin
                w     = SELW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign winner = pick(bus.req, last);
    assign load   = (|bus.req) && (state == IDLE || bus.dout_ready);

    always_comb begin
        bus.gnt = '0;
        if (!reset && load)
            bus.gnt[winner] = 1'b1;
    end

    // p0 -> p1: capture the granted word into the output register
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            vld_p1  <= 1'b0;
            dout_p1 <= '0;
            sel_p1  <= '0;
            last    <= SELW'(N - 1);
        end else if (load) begin
            state   <= HOLD;
            vld_p1  <= 1'b1;
            dout_p1 <= bus.din[int'(winner) * W +: W];
            sel_p1  <= winner;
            last    <= winner;
        end else if (state == HOLD && bus.dout_ready) begin
            state   <= IDLE;
            vld_p1  <= 1'b0;
        end
    end

    assign bus.dout       = dout_p1;
    assign bus.sel        = sel_p1;
    assign bus.dout_valid = vld_p1;
    assign bus.busy       = (state == HOLD);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter (N=8, W=8) with hand-computed expectations.
module tb_mux_rr_arbiter;

    logic clk;
    logic reset;
    int   total;
    int   passed;

    mux_rr_arbiter_if #(.N(8), .W(8)) bus ();

    mux_rr_arbiter #(.N(8), .W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] d, input logic [2:0] s,
                           input logic v);
        chk({tag, ".dout"}, 32'(bus.dout), 32'(d));
        chk({tag, ".sel"}, 32'(bus.sel), 32'(s));
        chk({tag, ".valid"}, 32'(bus.dout_valid), 32'(v));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(v));
    endtask

    initial begin
        total  = 0;
        passed = 0;

        // Reset held two cycles with every requester asserting
        reset          = 1'b1;
        bus.req        = 8'hFF;
        bus.din        = '0;
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 8; i++) bus.din[i*8 +: 8] = 8'(i * 8'h11);
        #1;
        chk("rst_gnt0", 32'(bus.gnt), 32'h00);
        tick();
        chk("rst_gnt1", 32'(bus.gnt), 32'h00);
        chk_out("rst1", 8'h00, 3'd0, 1'b0);
        tick();
        chk_out("rst2", 8'h00, 3'd0, 1'b0);

        // Single requester 5
        reset   = 1'b0;
        bus.req = 8'h00;
        bus.din = '0;
        #1;
        chk("idle_gnt", 32'(bus.gnt), 32'h00);
        bus.din[5*8 +: 8] = 8'hA5;
        bus.req = 8'h20;
        #1;
        chk("single_gnt", 32'(bus.gnt), 32'h20);
        tick();
        chk_out("single_k1", 8'hA5, 3'd5, 1'b1);
        bus.req = 8'h00;
        #1;
        chk("single_drop_gnt", 32'(bus.gnt), 32'h00);
        tick();
        chk_out("single_k2", 8'hA5, 3'd5, 1'b0);

        // Reset pulse so the pointer restarts at N-1
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // Full load: grants 0..7 then 0, one per cycle
        for (int i = 0; i < 8; i++) bus.din[i*8 +: 8] = 8'(i * 8'h11);
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk($sformatf("full_gnt%0d", k), 32'(bus.gnt), 32'(8'h01 << (k % 8)));
            tick();
            chk_out($sformatf("full%0d", k), 8'((k % 8) * 8'h11), 3'(k % 8), 1'b1);
        end

        // Load requester 3 (dout=33), then backpressure for 3 cycles
        bus.req = 8'h08;
        #1;
        chk("bp_load_gnt", 32'(bus.gnt), 32'h08);
        tick();
        chk_out("bp_load", 8'h33, 3'd3, 1'b1);
        bus.dout_ready = 1'b0;
        bus.req = 8'h01;
        #1;
        chk("bp_gnt0", 32'(bus.gnt), 32'h00);
        tick();
        chk_out("bp0", 8'h33, 3'd3, 1'b1);
        bus.req = 8'hF0;
        #1;
        chk("bp_gnt1", 32'(bus.gnt), 32'h00);
        tick();
        chk_out("bp1", 8'h33, 3'd3, 1'b1);
        bus.req = 8'h41;
        #1;
        chk("bp_gnt2", 32'(bus.gnt), 32'h00);
        tick();
        chk_out("bp2", 8'h33, 3'd3, 1'b1);
        bus.dout_ready = 1'b1;
        #1;
        chk("bp_release_gnt", 32'(bus.gnt), 32'h40);
        tick();
        chk_out("bp_release", 8'h66, 3'd6, 1'b1);

        // Wrap-around from last=6 with req=82: 7 then 1
        bus.req = 8'h82;
        #1;
        chk("wrap_gnt7", 32'(bus.gnt), 32'h80);
        tick();
        chk_out("wrap7", 8'h77, 3'd7, 1'b1);
        #1;
        chk("wrap_gnt1", 32'(bus.gnt), 32'h02);
        tick();
        chk_out("wrap1", 8'h11, 3'd1, 1'b1);
        bus.req = 8'h00;
        tick();
        chk_out("drain", 8'h11, 3'd1, 1'b0);

        // Reset in HOLD with sel=4, then req=09 grants 0 then 3
        bus.req = 8'h10;
        tick();
        chk_out("mid_load", 8'h44, 3'd4, 1'b1);
        bus.dout_ready = 1'b0;
        bus.req = 8'h09;
        reset = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt), 32'h00);
        tick();
        chk_out("mid_rst", 8'h00, 3'd0, 1'b0);
        reset = 1'b0;
        bus.dout_ready = 1'b1;
        #1;
        chk("mid_gnt0", 32'(bus.gnt), 32'h01);
        tick();
        chk_out("mid0", 8'h00, 3'd0, 1'b1);
        #1;
        chk("mid_gnt3", 32'(bus.gnt), 32'h08);
        tick();
        chk_out("mid3", 8'h33, 3'd3, 1'b1);
        bus.req = 8'h00;
        tick();
        chk_out("mid_drain", 8'h33, 3'd3, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
Round-robin arbiter that shares one N-to-1 multiplexed output channel between N requesters. It drives the select code of an external N-to-1 mux through the `sel` port. It captures the selected requester's data into an output register and presents it downstream with a valid/ready handshake. It sits between N producer blocks and a single shared consumer.

Parameters:
N, 8, number of requesters (2..16).
W, 8, data width per requester.
SELW, $clog2(N), select width (derived; do not override).

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
req  input  N  req[i]=1: requester i has a valid word on din.
din  input  N*W  packed input data; requester i occupies bits [i*W +: W].
gnt  output  N  one-hot, combinational; gnt[i]=1 means din[i] is captured at this rising edge.
sel  output  SELW  registered index of the requester whose word is in dout; drives the external mux select.
dout  output  W  registered output word.
dout_valid  output  1  dout holds an untransferred word.
dout_ready  input  1  consumer accepts dout this cycle.
busy  output  1  1 when the state machine is in HOLD.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset).
- Reset, sampled on a rising edge:
  - state=IDLE, dout_valid=0, dout=0, sel=0.
  - Round-robin pointer last=N-1, so index 0 has highest priority first.
  - gnt=0 while reset=1.
- States:
  - IDLE: output register empty.
  - HOLD: output register full, dout_valid=1.
- Load condition:
  - load = |req && (state==IDLE || dout_ready).
  - dout_ready is ignored in IDLE.
- Winner selection:
  - Winner = first index with req=1, searching last+1, last+2, ... with mod-N wrap.
  - This is a pure function of req and last.
- gnt:
  - gnt[winner]=1 only when load=1; otherwise gnt=0.
  - gnt is combinational in the same cycle. A requester treats req&&gnt at the edge as consumed and may change din or drop req in the next cycle.
- On a load edge:
  - dout<=din[winner], sel<=winner, last<=winner, dout_valid<=1, state<=HOLD.
- IDLE transitions:
  - Stays IDLE while req==0.
  - load -> HOLD.
  - Latency: req rises in cycle k -> gnt in cycle k -> dout_valid=1 and dout/sel updated in cycle k+1.
- HOLD transitions:
  - dout_ready=0: dout, sel and dout_valid held stable, gnt=0, req changes ignored.
  - dout_ready=1 and |req: transfer completes and the next winner loads on the same edge. Stays HOLD (back-to-back, one word per cycle).
  - dout_ready=1 and req==0: dout_valid<=0, state<=IDLE. dout and sel keep their last value.
- Fairness: with all requesters continuously requesting, each is granted exactly once per N consecutive grants.
- busy = (state==HOLD) = dout_valid.
- Reset has priority over every other event. Reset mid-HOLD discards the held word with no transfer, and the pointer returns to N-1.
- Non-power-of-two N: indices >= N are never produced on sel; mod-N wrap is exact.

Test Plan:
- Reset: hold reset=1 for 2 cycles with req=8'hFF -> gnt=0, dout_valid=0, sel=0, dout=0, busy=0.
- Single requester: req=8'h20, din[5]=8'hA5, dout_ready=1 -> gnt=8'h20 in cycle k; cycle k+1 dout=8'hA5, sel=5, dout_valid=1; req dropped -> cycle k+2 dout_valid=0.
- Full load: req=8'hFF held, din[i]=i*8'h11, dout_ready=1 -> grants 0,1,...,7,0 one per cycle; dout sequence 8'h00,8'h11,...,8'h77,8'h00, no bubbles.
- Backpressure: HOLD with dout=8'h33, dout_ready=0 for 3 cycles while req changes -> dout, sel and dout_valid stable, gnt=0; dout_ready=1 -> gnt to next winner that cycle, new dout next cycle.
- Wrap-around: last=6, req=8'h82 -> index 7 granted first, then 1 (sel 7 then 1).
- Reset mid-operation: reset in HOLD with sel=4, then req=8'h09 -> dout_valid=0 after reset; first grant goes to 0, then 3.
